// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_if
// Brief    : Instruction-memory, redirect and decode-side signals of fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fetch_err;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_err,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_err,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, inst_ready
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : RV32I fetch stage: PC, credit-limited imem requests, instruction
//            FIFO, redirect flush. Optional macro FETCH_MISALIGN_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);
  localparam int c_pw = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_cw = $clog2(FIFO_DEPTH + 1);
  localparam int c_ow = $clog2(MAX_OUTSTANDING + 1);
  localparam int c_tw = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [c_cw-1:0] c_cnt_one  = 1;
  localparam logic [c_cw-1:0] c_cnt_full = c_cw'(FIFO_DEPTH);
  localparam logic [c_pw-1:0] c_ptr_one  = 1;
  localparam logic [c_ow-1:0] c_os_one   = 1;
  localparam logic [c_tw-1:0] c_tag_one  = 1;
  localparam logic [c_tw-1:0] c_tag_last = c_tw'(MAX_OUTSTANDING - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t          r_state, w_state_next;
  logic [31:0]     r_pc;
  logic [c_ow-1:0] r_outstanding, r_discard, w_os_next;
  logic [c_cw-1:0] r_count, w_count_next;
  logic [c_pw-1:0] r_wptr, r_rptr;
  logic [31:0]     r_fifo_inst [FIFO_DEPTH];
  logic [31:0]     r_fifo_pc   [FIFO_DEPTH];
  logic [31:0]     r_tag       [MAX_OUTSTANDING];
  logic [c_tw-1:0] r_tag_wptr, r_tag_rptr, w_tag_wptr_inc, w_tag_rptr_inc;
  logic            w_req, w_grant, w_rsp, w_push, w_pop, w_valid, w_err_block;
  logic [31:0]     w_credit;
  logic [31:0]     w_redirect_pc;

  assign w_valid       = (r_count != '0);
  assign w_pop         = w_valid && bus.inst_ready;
  assign w_grant       = w_req && bus.imem_gnt;
  // Stray responses with nothing outstanding (e.g. after a reset) are ignored.
  assign w_rsp         = bus.imem_rvalid && (r_outstanding != '0);
  assign w_push        = w_rsp && (r_discard == '0) && !bus.redirect;
  assign w_redirect_pc = {bus.redirect_pc[31:2], 2'b00};

  assign w_tag_wptr_inc = (r_tag_wptr == c_tag_last) ? '0 : r_tag_wptr + c_tag_one;
  assign w_tag_rptr_inc = (r_tag_rptr == c_tag_last) ? '0 : r_tag_rptr + c_tag_one;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_fetch_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_err <= 1'b0;
    end else if ((r_state == FETCH) && bus.redirect) begin
      r_fetch_err <= |bus.redirect_pc[1:0];
    end
  end
  assign w_err_block = r_fetch_err;
`else
  assign w_err_block = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_req        = 1'b0;
    // Credits cover both words already buffered and words still in flight.
    w_credit     = 32'(r_outstanding) + 32'(r_count) - 32'(w_pop);
    case (r_state)
      IDLE:    w_state_next = FETCH;
      FETCH:   w_req = !w_err_block
                       && (32'(r_outstanding) < 32'(MAX_OUTSTANDING))
                       && (w_credit < 32'(FIFO_DEPTH));
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_os_next    = r_outstanding;
    w_count_next = r_count;
    if (w_grant && !w_rsp) begin
      w_os_next = r_outstanding + c_os_one;
    end else if (!w_grant && w_rsp) begin
      w_os_next = r_outstanding - c_os_one;
    end
    if (w_push && !w_pop) begin
      w_count_next = r_count + c_cnt_one;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - c_cnt_one;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_count       <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_tag_wptr    <= '0;
      r_tag_rptr    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_inst[i] <= '0;
        r_fifo_pc[i]   <= '0;
      end
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        r_tag[i] <= '0;
      end
    end else if (r_state == IDLE) begin
      if (bus.redirect) begin
        r_pc <= w_redirect_pc;
      end
    end else begin
      r_outstanding <= w_os_next;
      if (w_grant) begin
        r_tag[r_tag_wptr] <= r_pc;
        r_tag_wptr        <= w_tag_wptr_inc;
      end
      if (w_rsp) begin
        r_tag_rptr <= w_tag_rptr_inc;
      end
      if (bus.redirect) begin
        // Everything still in flight after this edge belongs to the old path.
        r_pc      <= w_redirect_pc;
        r_discard <= w_os_next;
        r_count   <= '0;
        r_wptr    <= '0;
        r_rptr    <= '0;
      end else begin
        if (w_grant) begin
          r_pc <= r_pc + 32'd4;
        end
        if (w_rsp && (r_discard != '0)) begin
          r_discard <= r_discard - c_os_one;
        end
        if (w_push) begin
          r_fifo_inst[r_wptr] <= bus.imem_rdata;
          r_fifo_pc[r_wptr]   <= r_tag[r_tag_rptr];
          r_wptr              <= r_wptr + c_ptr_one;
        end
        if (w_pop) begin
          r_rptr <= r_rptr + c_ptr_one;
        end
        r_count <= w_count_next;
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_rsp && (r_discard == '0) && (r_count == c_cnt_full)));

  assign bus.imem_req   = w_req;
  assign bus.imem_addr  = r_pc;
  assign bus.inst_valid = w_valid;
  assign bus.inst       = r_fifo_inst[r_rptr];
  assign bus.inst_pc    = r_fifo_pc[r_rptr];
  assign bus.fetch_err  = w_err_block;
endmodule
`default_nettype wire
